fixedpoint_accumulator: RTL and testbench

- Sequential stage directly downstream of the fixed-point multiplier.
- Sums a frame of N_ACC signed fixed-point products into a wider fixed-point accumulator and saturates on overflow.
- Presents the frame result through a valid/ready handshake.
- Typical use: the multiplier's 5.20 output feeds in_data, giving a dot-product/MAC datapath.

---
 rtl/fixedpoint_accumulator.sv | 157 +++++++++++++++
 tb/tb_fixedpoint_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fixedpoint_accumulator.sv
// Frame accumulator for signed fixed-point samples.
// Each frame sums N_ACC samples into a saturating WIO.WFO accumulator.
// The frame result and a sticky per-frame overflow flag are presented through
// a valid/ready handshake. Typical use is downstream of a 5.20 multiplier to
// build a MAC / dot-product datapath.
module fixedpoint_accumulator #(
  parameter int WII   = 5,   // input integer bits, sign included
  parameter int WFI   = 20,  // input fractional bits
  parameter int WIO   = 8,   // accumulator integer bits, sign included (>= WII)
  parameter int WFO   = 20,  // accumulator fractional bits
  parameter int N_ACC = 16,  // samples per frame (>= 1)
  parameter int CW    = 8    // frame counter width, 2**CW >= N_ACC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WII+WFI-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   FixedPoint_Acc_Out,
  output logic                 overFlow
);

  localparam int WI = WII + WFI;   // input width
  localparam int WO = WIO + WFO;   // accumulator / output width
  localparam int WA = WII + WFO;   // input rescaled to output fraction, before sign extension
  localparam logic [CW-1:0] LAST = CW'(N_ACC - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state_q;
  logic [WO-1:0]      acc_q;
  logic [CW-1:0]      cnt_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic [WO-1:0]      res_q;
  logic               res_ovf_q;

  // ---------------------------------------------------------------------------
  // Alignment of the input sample onto the accumulator's binary point.
  // Extra output fraction bits are zero-filled; missing ones are dropped,
  // which truncates toward -inf for two's complement values.
  // ---------------------------------------------------------------------------
  logic signed [WA-1:0] in_scaled;
  logic signed [WO-1:0] aligned;

  generate
    if (WFO > WFI) begin : g_shl
      assign in_scaled = {in_data, {(WFO-WFI){1'b0}}};
    end else if (WFO == WFI) begin : g_eq
      assign in_scaled = in_data;
    end else begin : g_trunc
      assign in_scaled = in_data[WI-1 -: WA];
    end
  endgenerate

  // Signed cast sign-extends the integer part up to WIO bits.
  assign aligned = WO'(in_scaled);

  // ---------------------------------------------------------------------------
  // Saturating add. A start in ACC restarts the frame, so a coincident sample
  // is added to zero instead of the stale partial sum.
  // ---------------------------------------------------------------------------
  logic           restart;
  logic [WO-1:0]  acc_base;
  logic [CW-1:0]  cnt_base;
  logic           ovf_base;
  logic [WO:0]    sum;
  logic           add_ovf;
  logic [WO-1:0]  acc_d;
  logic [CW-1:0]  cnt_d;
  logic           ovf_d;
  logic           xfer;
  logic           last_smp;

  assign restart  = start && (state_q == ACC);
  assign acc_base = restart ? '0 : acc_q;
  assign cnt_base = restart ? '0 : cnt_q;
  assign ovf_base = restart ? 1'b0 : ovf_q;

  // One guard bit: the top two bits disagree only on overflow.
  assign sum     = {acc_base[WO-1], acc_base} + {aligned[WO-1], aligned};
  assign add_ovf = sum[WO] ^ sum[WO-1];
  assign acc_d   = add_ovf ? {sum[WO], {(WO-1){~sum[WO]}}} : sum[WO-1:0];
  assign cnt_d   = cnt_base + 1'b1;
  assign ovf_d   = ovf_base | add_ovf;

  assign in_ready = (state_q == ACC);
  assign xfer     = in_valid && in_ready;
  assign last_smp = (cnt_base == LAST);

  // Frame control FSM; all outputs except in_ready are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        ACC: begin
          if (xfer) begin
            acc_q <= acc_d;
            if (last_smp) begin
              res_q       <= acc_d;
              res_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              state_q     <= DONE;
            end else begin
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end else if (restart) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        DONE: begin
          // Result held until accepted; a start only counts with the accept.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (start) begin
              state_q <= ACC;
              acc_q   <= '0;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid          = out_valid_q;
  assign FixedPoint_Acc_Out = res_q;
  assign overFlow           = res_ovf_q;

endmodule

// File: tb/tb_fixedpoint_accumulator.sv
// Scoreboard bench for fixedpoint_accumulator (5.20 in, 6.20 out, 4-sample frames).
module tb_fixedpoint_accumulator;
  localparam int WII = 5, WFI = 20, WIO = 6, WFO = 20, N_ACC = 4, CW = 8;
  localparam int WI = WII + WFI, WO = WIO + WFO;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [WI-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WO-1:0] acc_out;
  logic          ovf;

  fixedpoint_accumulator #(
    .WII(WII), .WFI(WFI), .WIO(WIO), .WFO(WFO), .N_ACC(N_ACC), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .FixedPoint_Acc_Out(acc_out), .overFlow(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [WO-1:0] data; logic ovf; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got=%h expected=none", acc_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_data", 32'(acc_out), 32'(e.data));
        chk("result_ovf",  32'(ovf),     32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive one sample and hold it until the DUT takes it (bounded).
  task automatic send(input logic [WI-1:0] d, input logic st);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    start    = st;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got=in_ready_low expected=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic expect_res(input logic [WO-1:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  localparam logic [WI-1:0] ONE  = 25'h0100000;
  localparam logic [WI-1:0] M1P5 = 25'h1E80000;
  localparam logic [WI-1:0] MAXV = 25'h0FFFFFF;
  localparam logic [WI-1:0] HALF = 25'h0080000;
  localparam logic [WI-1:0] QTR  = 25'h0040000;
  localparam logic [WI-1:0] TWO  = 25'h0200000;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_data",      32'(acc_out),   32'd0);
    chk("reset_ovf",       32'(ovf),       32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // 1: four 1.0 back-to-back -> 4.0, single-cycle out_valid
    pulse_start();
    expect_res(26'h0400000, 1'b0);
    for (int i = 0; i < 3; i++) send(ONE, 1'b0);
    chk("t1_valid_before_last", 32'(out_valid), 32'd0);
    send(ONE, 1'b0);
    chk("t1_valid_after_last", 32'(out_valid), 32'd1);
    tick();
    chk("t1_valid_one_cycle", 32'(out_valid), 32'd0);
    tick();

    // 2: four -1.5 with bubbles (junk data on in_data) -> -6.0
    pulse_start();
    expect_res(26'h3A00000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(M1P5, 1'b0);
      in_data = 25'h0123456;
      tick();
      tick();
    end
    tick();

    // 3: four max -> saturated, then a clean frame with flag cleared
    pulse_start();
    expect_res(26'h1FFFFFF, 1'b1);
    for (int i = 0; i < 4; i++) send(MAXV, 1'b0);
    tick();
    tick();
    pulse_start();
    expect_res(26'h0400000, 1'b0);
    for (int i = 0; i < 4; i++) send(ONE, 1'b0);
    tick();
    tick();

    // 4: back-pressure for 5 cycles, then accept together with start
    out_ready = 1'b0;
    pulse_start();
    expect_res(26'h0400000, 1'b0);
    for (int i = 0; i < 4; i++) send(ONE, 1'b0);
    in_valid = 1'b1;
    in_data  = ONE;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid",    32'(out_valid), 32'd1);
      chk("t4_hold_data",     32'(acc_out),   32'h0400000);
      chk("t4_hold_ovf",      32'(ovf),       32'd0);
      chk("t4_hold_in_ready", 32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    start     = 1'b1;
    in_valid  = 1'b0;
    tick();
    start = 1'b0;
    chk("t4_accept_valid",    32'(out_valid), 32'd0);
    chk("t4_accept_in_ready", 32'(in_ready),  32'd1);
    // Frame opened by the accept+start; nothing driven during the hold leaked in.
    expect_res(26'h0100000, 1'b0);
    for (int i = 0; i < 4; i++) send(QTR, 1'b0);
    tick();
    tick();

    // 5: asynchronous reset mid-frame
    pulse_start();
    for (int i = 0; i < 2; i++) send(ONE, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid",    32'(out_valid), 32'd0);
    chk("t5_rst_data",     32'(acc_out),   32'd0);
    chk("t5_rst_ovf",      32'(ovf),       32'd0);
    chk("t5_rst_in_ready", 32'(in_ready),  32'd0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    expect_res(26'h0200000, 1'b0);
    for (int i = 0; i < 4; i++) send(HALF, 1'b0);
    tick();
    tick();

    // 6: restart coincident with a sample -> partial sum discarded
    pulse_start();
    for (int i = 0; i < 3; i++) send(ONE, 1'b0);
    expect_res(26'h0500000, 1'b0);
    send(TWO, 1'b1);
    for (int i = 0; i < 3; i++) send(ONE, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=hang expected=finish");
    $fatal(1, "timeout");
  end
endmodule
